// File: rtl/pdm_decimator.sv
// pdm_decimator
// Counts ones in the 1-bit PDM microphone stream over a window of DECIM bit-clock periods
// and emits one signed PCM sample per window through a valid/ack handshake. BCLK is treated
// as a level synchronous to CLK; only its rising edges advance the window. After each enable
// the first WARM completed windows are discarded while the microphone settles.
//
// Ports:
//   CLK        in   system clock (the only clock)
//   RESET      in   asynchronous active-low reset
//   EN         in   block enable; low returns to idle and clears counters and PCM_VALID
//   BCLK       in   microphone bit clock, sampled as data
//   PDM_DATA   in   microphone data, asynchronous to CLK
//   PCM_ACK    in   consumer accepts PCM while PCM_VALID is high
//   PCM        out  signed two's complement sample, range -DECIM/2..+DECIM/2
//   PCM_VALID  out  sample available
//   OVERRUN    out  sticky: a sample was overwritten before being acknowledged
//   BUSY       out  high while warming up or running
module pdm_decimator #(
   parameter int unsigned DECIM = 64,
   parameter int unsigned PCM_W = 8,
   parameter int unsigned WARM  = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             EN,
   input  logic             BCLK,
   input  logic             PDM_DATA,
   input  logic             PCM_ACK,
   output logic [PCM_W-1:0] PCM,
   output logic             PCM_VALID,
   output logic             OVERRUN,
   output logic             BUSY
);

   localparam int unsigned BIT_W  = $clog2(DECIM);
   localparam int unsigned ONES_W = $clog2(DECIM + 1);
   localparam int unsigned WARM_W = (WARM > 0) ? $clog2(WARM + 1) : 1;

   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DECIM - 1);
   localparam logic [PCM_W-1:0]  HALF     = PCM_W'(DECIM / 2);
   localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(WARM);

   typedef enum logic [1:0] {StIdle, StWarmup, StRun} state_e;

   localparam state_e FIRST_ST = (WARM == 0) ? StRun : StWarmup;

   state_e              state_q, state_d;
   logic                pdm_meta_q, pdm_s_q;
   logic                bclk_q;
   logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
   logic [ONES_W-1:0]   ones_q, ones_d;
   logic [WARM_W-1:0]   warmcnt_q, warmcnt_d;
   logic [WARM_W-1:0]   warm_next;
   logic [PCM_W-1:0]    pcm_q, pcm_d;
   logic [PCM_W-1:0]    sample;
   logic                valid_q, valid_d;
   logic                overrun_q, overrun_d;
   logic                rise;
   logic                win_end;

   assign rise      = BCLK & ~bclk_q;
   assign win_end   = rise && (bitcnt_q == LAST_BIT);
   assign warm_next = warmcnt_q + 1'b1;
   // The final bit of the window is folded in here rather than waiting for ones_q to update.
   // Modular PCM_W arithmetic is exact because the result always fits the signed range.
   assign sample    = PCM_W'(ones_q) + PCM_W'(pdm_s_q) - HALF;

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      ones_d    = ones_q;
      warmcnt_d = warmcnt_q;
      pcm_d     = pcm_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;

      if (!EN) begin
         state_d   = StIdle;
         bitcnt_d  = '0;
         ones_d    = '0;
         warmcnt_d = '0;
         valid_d   = 1'b0;
      end else begin
         if (valid_q && PCM_ACK) begin
            valid_d = 1'b0;
         end

         // Shared window accumulation for warm-up and run.
         if (rise && (state_q != StIdle)) begin
            if (bitcnt_q == LAST_BIT) begin
               bitcnt_d = '0;
               ones_d   = '0;
            end else begin
               bitcnt_d = bitcnt_q + 1'b1;
               ones_d   = ones_q + ONES_W'(pdm_s_q);
            end
         end

         unique case (state_q)
            StIdle: begin
               state_d = FIRST_ST;
            end
            StWarmup: begin
               if (win_end) begin
                  warmcnt_d = warm_next;
                  if (warm_next == WARM_MAX) begin
                     state_d = StRun;
                  end
               end
            end
            StRun: begin
               if (win_end) begin
                  pcm_d   = sample;
                  valid_d = 1'b1;
                  // An ack in the load cycle retires the old sample, so no overrun.
                  if (valid_q && !PCM_ACK) begin
                     overrun_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= StIdle;
         pdm_meta_q <= 1'b0;
         pdm_s_q    <= 1'b0;
         bclk_q     <= 1'b0;
         bitcnt_q   <= '0;
         ones_q     <= '0;
         warmcnt_q  <= '0;
         pcm_q      <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pdm_meta_q <= PDM_DATA;
         pdm_s_q    <= pdm_meta_q;
         bclk_q     <= BCLK;
         bitcnt_q   <= bitcnt_d;
         ones_q     <= ones_d;
         warmcnt_q  <= warmcnt_d;
         pcm_q      <= pcm_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign PCM       = pcm_q;
   assign PCM_VALID = valid_q;
   assign OVERRUN   = overrun_q;
   assign BUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: two instances (WARM=0 and WARM=4) share the bit stream. A window
// model pushes expected samples into per-instance queues; monitors pop on each PCM_VALID rise.
module tb_pdm_decimator;

   localparam int unsigned DECIM = 64;
   localparam int unsigned PCM_W = 8;
   localparam int unsigned WARM4 = 4;
   localparam int          H     = 10;  // BCLK half-period in CLK cycles

   logic             CLK = 1'b0;
   logic             RESET = 1'b0;
   logic             EN = 1'b0;
   logic             BCLK = 1'b0;
   logic             PDM_DATA = 1'b0;
   logic             ack0_man = 1'b0;
   logic             auto0 = 1'b0;
   logic             ack0, ack4;
   logic [PCM_W-1:0] pcm0, pcm4;
   logic             valid0, valid4, ovr0, ovr4, busy0, busy4;

   assign ack0 = ack0_man | (auto0 & valid0);
   assign ack4 = valid4;

   always #5 CLK = ~CLK;

   pdm_decimator #(.DECIM(DECIM), .PCM_W(PCM_W), .WARM(0)) dut0 (
      .CLK(CLK), .RESET(RESET), .EN(EN), .BCLK(BCLK), .PDM_DATA(PDM_DATA), .PCM_ACK(ack0),
      .PCM(pcm0), .PCM_VALID(valid0), .OVERRUN(ovr0), .BUSY(busy0)
   );

   pdm_decimator #(.DECIM(DECIM), .PCM_W(PCM_W), .WARM(WARM4)) dut4 (
      .CLK(CLK), .RESET(RESET), .EN(EN), .BCLK(BCLK), .PDM_DATA(PDM_DATA), .PCM_ACK(ack4),
      .PCM(pcm4), .PCM_VALID(valid4), .OVERRUN(ovr4), .BUSY(busy4)
   );

   int tests = 0;
   int fails = 0;
   int q0[$];
   int q4[$];
   bit push0 = 1'b0;
   int m_bits = 0;
   int m_ones = 0;
   int m_wins = 0;
   int exp0 = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_bits = 0;
      m_ones = 0;
      m_wins = 0;
   endtask

   // One bit presented at a BCLK rise; a full window yields (ones - DECIM/2).
   task automatic model_bit(input logic b);
      int val;
      m_ones += int'(b);
      m_bits++;
      if (m_bits == DECIM) begin
         val  = m_ones - int'(DECIM / 2);
         exp0 = val;
         if (push0) q0.push_back(val);
         if (m_wins >= int'(WARM4)) q4.push_back(val);
         m_wins++;
         m_bits = 0;
         m_ones = 0;
      end
   endtask

   // kind: 0 all ones, 1 all zeros, 2 alternating 1/0, otherwise random.
   task automatic send_window(input int kind, input int nbits, input bit ack_on_load,
                              input bit chk_lat);
      for (int i = 0; i < nbits; i++) begin
         logic b;
         case (kind)
            0:       b = 1'b1;
            1:       b = 1'b0;
            2:       b = (i % 2 == 0);
            default: b = 1'($urandom_range(0, 1));
         endcase
         BCLK     = 1'b0;
         PDM_DATA = b;
         repeat (H) @(posedge CLK);
         #1;
         BCLK = 1'b1;
         model_bit(b);
         if (i == int'(DECIM) - 1) begin
            if (chk_lat) check("valid_before_last_rise", int'(valid0), 0);
            if (ack_on_load) ack0_man = 1'b1;
            @(posedge CLK);
            #1;
            ack0_man = 1'b0;
            if (chk_lat) begin
               check("valid_1cycle_after_last_rise", int'(valid0), 1);
               check("pcm_all_ones", int'($signed(pcm0)), 32);
            end
            repeat (H - 1) @(posedge CLK);
            #1;
         end else begin
            repeat (H) @(posedge CLK);
            #1;
         end
      end
   endtask

   task automatic ack_pulse();
      ack0_man = 1'b1;
      @(posedge CLK);
      #1;
      ack0_man = 1'b0;
   endtask

   // Monitors: a PCM_VALID rise marks a fresh sample to compare with the queue head.
   initial begin
      logic prev;
      int   e;
      prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (RESET && valid0 && !prev) begin
            if (q0.size() == 0) begin
               check("dut0_unexpected_sample", int'($signed(pcm0)), 9999);
            end else begin
               e = q0.pop_front();
               check("dut0_sample", int'($signed(pcm0)), e);
            end
         end
         prev = RESET ? valid0 : 1'b0;
      end
   end

   initial begin
      logic prev;
      int   e;
      prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (RESET && valid4 && !prev) begin
            if (q4.size() == 0) begin
               check("dut4_unexpected_sample", int'($signed(pcm4)), 9999);
            end else begin
               e = q4.pop_front();
               check("dut4_sample", int'($signed(pcm4)), e);
            end
         end
         prev = RESET ? valid4 : 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      check("rst_pcm0", int'(pcm0), 0);
      check("rst_valid0", int'(valid0), 0);
      check("rst_ovr0", int'(ovr0), 0);
      check("rst_busy0", int'(busy0), 0);
      check("rst_pcm4", int'(pcm4), 0);
      check("rst_valid4", int'(valid4), 0);
      check("rst_ovr4", int'(ovr4), 0);
      check("rst_busy4", int'(busy4), 0);

      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      EN = 1'b1;
      model_reset();
      @(posedge CLK);
      #1;
      check("busy0_after_en", int'(busy0), 1);
      check("busy4_after_en", int'(busy4), 1);

      // W1: all ones, latency and ack behaviour.
      push0 = 1'b1;
      auto0 = 1'b0;
      send_window(0, DECIM, 1'b0, 1'b1);
      ack_pulse();
      check("valid0_cleared_by_ack", int'(valid0), 0);

      // W2..W4: all zeros, alternating, random.
      auto0 = 1'b1;
      send_window(1, DECIM, 1'b0, 1'b0);
      send_window(2, DECIM, 1'b0, 1'b0);
      send_window(3, DECIM, 1'b0, 1'b0);
      check("valid4_none_during_warmup", q4.size(), 0);

      // W5 held unacknowledged; W6 loads with ack in the same cycle.
      auto0 = 1'b0;
      send_window(3, DECIM, 1'b0, 1'b0);
      push0 = 1'b0;
      send_window(3, DECIM, 1'b1, 1'b0);
      check("ackload_valid0", int'(valid0), 1);
      check("ackload_ovr0", int'(ovr0), 0);
      check("ackload_pcm0", int'($signed(pcm0)), exp0);
      ack_pulse();
      check("ackload_valid0_cleared", int'(valid0), 0);

      // W7 loads, W8 overwrites it without ack.
      push0 = 1'b1;
      send_window(3, DECIM, 1'b0, 1'b0);
      push0 = 1'b0;
      send_window(3, DECIM, 1'b0, 1'b0);
      check("overrun_set", int'(ovr0), 1);
      check("overrun_valid0", int'(valid0), 1);
      check("overrun_pcm0_second", int'($signed(pcm0)), exp0);

      // W9: drop EN after 30 bits.
      send_window(3, 30, 1'b0, 1'b0);
      EN = 1'b0;
      @(posedge CLK);
      #1;
      check("en_drop_valid0", int'(valid0), 0);
      check("en_drop_busy0", int'(busy0), 0);
      check("en_drop_busy4", int'(busy4), 0);
      check("en_drop_ovr0_holds", int'(ovr0), 1);
      check("en_drop_pcm0_holds", int'($signed(pcm0)), exp0);
      repeat (5) @(posedge CLK);
      #1;

      // Re-enable: fresh windows, dut4 warms up again.
      EN = 1'b1;
      model_reset();
      push0 = 1'b1;
      auto0 = 1'b1;
      for (int w = 0; w < 4; w++) send_window(3, DECIM, 1'b0, 1'b0);
      auto0 = 1'b0;
      send_window(3, DECIM, 1'b0, 1'b0);
      check("reenable_q4_drained", q4.size(), 0);

      // Asynchronous reset mid-window.
      send_window(3, 20, 1'b0, 1'b0);
      RESET = 1'b0;
      #1;
      check("async_rst_pcm0", int'(pcm0), 0);
      check("async_rst_valid0", int'(valid0), 0);
      check("async_rst_ovr0", int'(ovr0), 0);
      check("async_rst_busy0", int'(busy0), 0);
      check("async_rst_busy4", int'(busy4), 0);
      check("async_rst_pcm4", int'(pcm4), 0);
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b1;
      EN    = 1'b0;
      repeat (2) @(posedge CLK);
      #1;

      check("q0_empty", q0.size(), 0);
      check("q4_empty", q4.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
